// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port: M0 (CPU) has fixed
// priority; M1 (debug/DMA) has a starvation guard and a bounded lock burst.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned LOCK_MAX     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_be,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_be,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic                m1_lock,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [LOCK_W-1:0] lock_cnt, lock_nxt;
  logic              yield, yield_nxt;

  // Grant selection and next-state; grants are held off while reset is low.
  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    state_nxt = state;
    lock_nxt  = lock_cnt;
    yield_nxt = 1'b0;
    wait_nxt  = '0;
    if (reset) begin
      case (state)
        ARB: begin
          if (yield && m0_req)                                  m0_gnt = 1'b1;
          else if (m1_req && wait_cnt == WAIT_W'(STARVE_LIMIT)) m1_gnt = 1'b1;
          else if (m0_req)                                      m0_gnt = 1'b1;
          else if (m1_req)                                      m1_gnt = 1'b1;
          if (m1_gnt && m1_lock) begin
            state_nxt = LOCKED;
            lock_nxt  = LOCK_W'(1);
          end
        end
        LOCKED: begin
          m1_gnt = m1_req;
          if (!m1_req || !m1_lock) begin
            state_nxt = ARB;
            lock_nxt  = '0;
          end else if (lock_cnt >= LOCK_W'(LOCK_MAX - 1)) begin
            // This beat completes the burst allowance: hand M0 the next slot.
            state_nxt = ARB;
            lock_nxt  = '0;
            yield_nxt = 1'b1;
          end else begin
            lock_nxt = lock_cnt + LOCK_W'(1);
          end
        end
        default: state_nxt = ARB;
      endcase
      if (m1_req && !m1_gnt) begin
        wait_nxt = (wait_cnt == WAIT_W'(STARVE_LIMIT)) ? wait_cnt
                                                       : wait_cnt + WAIT_W'(1);
      end
    end
  end

  // Memory port follows the granted master, defaulting to M0's fields.
  assign mem_we    = (m0_gnt & m0_we) | (m1_gnt & m1_we);
  assign mem_be    = m1_gnt ? m1_be    : m0_be;
  assign mem_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign mem_wdata = m1_gnt ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ARB;
      wait_cnt  <= '0;
      lock_cnt  <= '0;
      yield     <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      lock_cnt  <= lock_nxt;
      yield     <= yield_nxt;
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we) m0_rdata <= mem_rdata;
      if (m1_gnt && !m1_we) m1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: priority, starvation guard, read latency,
// lock bursts with forced yield, lock drop and reset during a read.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [3:0]  m0_be;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [3:0]  m1_be;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int beat;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents: one marked word, everything else is address ^ 0x5A5A5A5A.
  assign mem_rdata = (mem_addr == 32'h8000_0004) ? 32'hDEAD_BEEF
                                                 : (mem_addr ^ 32'h5A5A_5A5A);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit exp_lk [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    bit exp_dr [5]  = '{1, 1, 1, 0, 1};

    reset = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'hF; m0_addr = 32'h8000_0000; m0_wdata = 32'h0;
    m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'hF; m1_addr = 32'h8000_0020; m1_wdata = 32'h0;
    m1_lock = 1'b0;

    // Reset asserted with both requesting.
    tick(); tick();
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_m1_rdata", m1_rdata, 0);
    reset = 1'b1; #1;
    check("rel_m0_gnt", m0_gnt, 1);
    check("rel_m1_gnt", m1_gnt, 0);
    check("rel_mem_we", mem_we, 1);
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    // M0 priority, then starvation guard hands M1 the fifth cycle.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8000_0010;
    m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'h3; m1_addr = 32'h8000_0020; m1_wdata = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("prio_m0_gnt%0d", i), m0_gnt, 1);
      check($sformatf("prio_m1_gnt%0d", i), m1_gnt, 0);
      check($sformatf("prio_addr%0d", i), mem_addr, 32'h8000_0010);
      tick();
      check($sformatf("prio_rvalid%0d", i), m0_rvalid, 1);
      check($sformatf("prio_rdata%0d", i), m0_rdata, 32'hDA5A_5A4A);
    end
    #1;
    check("starve_m1_gnt", m1_gnt, 1);
    check("starve_m0_gnt", m0_gnt, 0);
    check("starve_mem_we", mem_we, 1);
    check("starve_addr", mem_addr, 32'h8000_0020);
    check("starve_wdata", mem_wdata, 32'h1234_5678);
    check("starve_be", mem_be, 4'h3);
    tick();
    check("starve_no_rv0", m0_rvalid, 0);
    check("starve_no_rv1", m1_rvalid, 0);
    m1_req = 1'b0; #1;
    check("regain_m0_gnt", m0_gnt, 1);
    tick();
    m0_req = 1'b0;
    tick();

    // M1 read latency and hold.
    m1_req = 1'b1; m1_we = 1'b0; m1_be = 4'hF; m1_addr = 32'h8000_0004; #1;
    check("rd_m1_gnt", m1_gnt, 1);
    check("rd_mem_we", mem_we, 0);
    tick();
    m1_req = 1'b0;
    check("rd_m1_rvalid", m1_rvalid, 1);
    check("rd_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    check("rd_m0_rvalid", m0_rvalid, 0);
    tick();
    check("rd_rvalid_drop", m1_rvalid, 0);
    check("rd_rdata_hold", m1_rdata, 32'hDEAD_BEEF);
    check("rd_m0_quiet", m0_rvalid, 0);

    // Alternating back-to-back reads.
    m0_req = 1'b1; m0_addr = 32'h8000_0010;
    tick();
    m0_req = 1'b0; m1_req = 1'b1; m1_addr = 32'h8000_0008;
    check("alt_rv0_a", m0_rvalid, 1);
    check("alt_rv1_a", m1_rvalid, 0);
    tick();
    m1_req = 1'b0;
    check("alt_rv0_b", m0_rvalid, 0);
    check("alt_rv1_b", m1_rvalid, 1);
    check("alt_rdata1", m1_rdata, 32'hDA5A_5A52);
    tick();

    // Lock burst: 8 M1 beats, forced yield to M0, then M1 resumes.
    beat = 0;
    m1_we = 1'b1; m1_lock = 1'b1;
    for (int c = 0; c < 11; c++) begin
      m0_req = (c >= 1 && c <= 8);
      m1_req = 1'b1;
      m1_addr = 32'h0000_0100 + 32'(beat * 4);
      m1_wdata = 32'(beat);
      #1;
      check($sformatf("lock_m1_gnt%0d", c), m1_gnt, 32'(exp_lk[c]));
      check($sformatf("lock_m0_gnt%0d", c), m0_gnt, 32'(!exp_lk[c]));
      tick();
      if (exp_lk[c]) beat++;
    end
    m1_req = 1'b0; m1_lock = 1'b0; m0_req = 1'b0;
    tick();

    // Lock dropped on the third beat: M0 served at once, no yield.
    for (int c = 0; c < 5; c++) begin
      m0_req = (c >= 1 && c <= 3);
      m1_req = 1'b1;
      m1_lock = (c < 2);
      #1;
      check($sformatf("drop_m1_gnt%0d", c), m1_gnt, 32'(exp_dr[c]));
      check($sformatf("drop_m0_gnt%0d", c), m0_gnt, 32'(!exp_dr[c]));
      tick();
    end
    m1_req = 1'b0; m0_req = 1'b0;
    tick();

    // Reset during an accepted M0 read with wait_cnt already at 2.
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8000_0010;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8000_0020;
    tick(); tick();
    #1;
    check("mid_m0_gnt", m0_gnt, 1);
    reset = 1'b0; #1;
    check("mid_gnt_off", m0_gnt, 0);
    check("mid_rdata_clr", m0_rdata, 0);
    tick();
    check("mid_no_rvalid", m0_rvalid, 0);
    #1 reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("post_m0_gnt%0d", c), m0_gnt, 32'(c < 4));
      check($sformatf("post_m1_gnt%0d", c), m1_gnt, 32'(c == 4));
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
